// File: rtl/power_iter_engine.sv
`timescale 1ns/1ps
// power_iter_engine: self-sequencing power iteration for an N x N unsigned matrix.
// Each iteration runs one MAC per cycle, a sequential max scan, a per-lane restoring
// divide for normalisation, and a max |delta| scan. The loop stops on convergence,
// on the iteration limit, or when the product vector is all zero.
module power_iter_engine #(
  parameter int N      = 4,
  parameter int A_W    = 4,
  parameter int V_W    = 4,
  parameter int Y_W    = 12,
  parameter int ITER_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N*N*A_W-1:0]    matrix,
  input  logic [N*V_W-1:0]      v_init,
  input  logic [V_W-1:0]        threshold,
  input  logic [ITER_W-1:0]     max_iter,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  err_zero,
  output logic [ITER_W-1:0]     iter_count,
  output logic [Y_W-1:0]        lambda_out,
  output logic [V_W-1:0]        max_diff,
  output logic [N*V_W-1:0]      v_out
);

  localparam int IW  = $clog2(N);
  localparam int D_W = Y_W + V_W;
  localparam int SW  = $clog2(D_W);
  localparam logic [IW-1:0]  LAST   = IW'(N - 1);
  localparam logic [SW-1:0]  D_LAST = SW'(D_W - 1);
  localparam logic [V_W-1:0] FS     = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MULT, S_MAX, S_SCALE, S_DIFF, S_CHECK, S_FIN
  } state_t;

  state_t              state;
  logic [V_W-1:0]      v_old [N];
  logic [V_W-1:0]      v_new [N];
  logic [Y_W-1:0]      y     [N];
  logic [Y_W-1:0]      ymax;
  logic [V_W-1:0]      diff_acc;
  logic [V_W-1:0]      thr;
  logic [ITER_W-1:0]   lim;
  logic [IW-1:0]       row;
  logic [IW-1:0]       col;
  logic [IW-1:0]       lane;
  logic [SW-1:0]       step;
  logic [Y_W-1:0]      rem;
  logic [D_W-1:0]      dvd;
  logic [D_W-2:0]      quo;

  // Unpacked views of the flat matrix and seed buses
  logic [A_W-1:0]      a_arr [N][N];
  logic [V_W-1:0]      seed  [N];

  genvar gr, gc;
  generate
    for (gr = 0; gr < N; gr++) begin : g_row
      assign seed[gr] = v_init[gr*V_W +: V_W];
      for (gc = 0; gc < N; gc++) begin : g_col
        assign a_arr[gr][gc] = matrix[(gr*N+gc)*A_W +: A_W];
      end
    end
  endgenerate

  // y * (2^V_W - 1) computed as a shift and subtract
  function automatic logic [D_W-1:0] scale_num(input logic [Y_W-1:0] yv);
    return {yv, {V_W{1'b0}}} - {{V_W{1'b0}}, yv};
  endfunction

  // One restoring-divide step: returns {next remainder, quotient bit}.
  // The remainder stays below the divisor, so modular Y_W-bit subtraction is exact.
  function automatic logic [Y_W:0] div_step(input logic [Y_W-1:0] rem_in,
                                            input logic           bit_in,
                                            input logic [Y_W-1:0] den);
    logic [Y_W:0] trial;
    trial = {rem_in, bit_in};
    if (trial >= {1'b0, den}) return {trial[Y_W-1:0] - den, 1'b1};
    return {trial[Y_W-1:0], 1'b0};
  endfunction

  // Clamp a quotient to the lane full scale
  function automatic logic [V_W-1:0] sat_lane(input logic [D_W-1:0] q);
    if (q > {{Y_W{1'b0}}, FS}) return FS;
    return q[V_W-1:0];
  endfunction

  function automatic logic [V_W-1:0] abs_diff(input logic [V_W-1:0] a,
                                              input logic [V_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic [A_W+V_W-1:0]  prod;
  logic [Y_W-1:0]      mac_sum;
  logic [ITER_W-1:0]   iter_next;
  logic [V_W-1:0]      lane_diff;

  assign prod      = {{V_W{1'b0}}, a_arr[row][col]} * {{A_W{1'b0}}, v_old[col]};
  assign mac_sum   = y[row] + Y_W'(prod);
  assign iter_next = iter_count + ITER_W'(1);
  assign lane_diff = abs_diff(v_new[lane], v_old[lane]);

  logic [D_W-1:0]      dvd_src;
  logic [Y_W-1:0]      rem_src;
  logic [D_W-2:0]      quo_src;
  logic [Y_W:0]        step_res;
  logic [D_W-1:0]      quo_next;

  // Divider step: the first step of each lane starts from the freshly scaled dividend
  always_comb begin
    dvd_src = dvd;
    rem_src = rem;
    quo_src = quo;
    if (step == '0) begin
      dvd_src = scale_num(y[lane]);
      rem_src = '0;
      quo_src = '0;
    end
    step_res = div_step(rem_src, dvd_src[D_W-1], ymax);
    quo_next = {quo_src, step_res[0]};
  end

  // Iteration controller and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      err_zero   <= 1'b0;
      iter_count <= '0;
      lambda_out <= '0;
      max_diff   <= '0;
      v_out      <= '0;
      ymax       <= '0;
      diff_acc   <= '0;
      thr        <= '0;
      lim        <= '0;
      row        <= '0;
      col        <= '0;
      lane       <= '0;
      step       <= '0;
      rem        <= '0;
      dvd        <= '0;
      quo        <= '0;
      for (int i = 0; i < N; i++) begin
        v_old[i] <= '0;
        v_new[i] <= '0;
        y[i]     <= '0;
      end
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        converged <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_LOAD;
              busy       <= 1'b1;
              converged  <= 1'b0;
              err_zero   <= 1'b0;
              iter_count <= '0;
            end
          end
          S_LOAD: begin
            for (int i = 0; i < N; i++) begin
              v_old[i] <= seed[i];
              y[i]     <= '0;
            end
            thr   <= threshold;
            lim   <= (max_iter == '0) ? ITER_W'(1) : max_iter;
            ymax  <= '0;
            row   <= '0;
            col   <= '0;
            state <= S_MULT;
          end
          S_MULT: begin
            y[row] <= mac_sum;
            if (col == LAST) begin
              col <= '0;
              if (row == LAST) begin
                row   <= '0;
                lane  <= '0;
                state <= S_MAX;
              end else begin
                row <= row + IW'(1);
              end
            end else begin
              col <= col + IW'(1);
            end
          end
          S_MAX: begin
            if (y[lane] > ymax) ymax <= y[lane];
            if (lane == LAST) begin
              lane  <= '0;
              step  <= '0;
              state <= S_SCALE;
            end else begin
              lane <= lane + IW'(1);
            end
          end
          S_SCALE: begin
            if (lane == '0 && step == '0 && ymax == '0) begin
              err_zero <= 1'b1;
              v_out    <= '0;
              for (int i = 0; i < N; i++) v_new[i] <= '0;
              done     <= 1'b1;
              state    <= S_FIN;
            end else begin
              rem <= step_res[Y_W:1];
              dvd <= {dvd_src[D_W-2:0], 1'b0};
              quo <= quo_next[D_W-2:0];
              if (step == D_LAST) begin
                step        <= '0;
                v_new[lane] <= sat_lane(quo_next);
                if (lane == LAST) begin
                  lane     <= '0;
                  diff_acc <= '0;
                  state    <= S_DIFF;
                end else begin
                  lane <= lane + IW'(1);
                end
              end else begin
                step <= step + SW'(1);
              end
            end
          end
          S_DIFF: begin
            if (lane_diff > diff_acc) diff_acc <= lane_diff;
            if (lane == LAST) begin
              lane  <= '0;
              state <= S_CHECK;
            end else begin
              lane <= lane + IW'(1);
            end
          end
          S_CHECK: begin
            iter_count <= iter_next;
            lambda_out <= ymax;
            max_diff   <= diff_acc;
            for (int i = 0; i < N; i++) v_out[i*V_W +: V_W] <= v_new[i];
            if (diff_acc <= thr) begin
              converged <= 1'b1;
              done      <= 1'b1;
              state     <= S_FIN;
            end else if (iter_next == lim) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              for (int i = 0; i < N; i++) begin
                v_old[i] <= v_new[i];
                y[i]     <= '0;
              end
              ymax  <= '0;
              row   <= '0;
              col   <= '0;
              state <= S_MULT;
            end
          end
          S_FIN: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
